// File: rtl/gen3_dllp_pkg.sv
// gen3_dllp_pkg: shared constants, FIFO entry type and DLLP CRC for the Gen3 DLLP extractor.
package gen3_dllp_pkg;
  localparam logic [7:0] SDP_B0 = 8'hF0;
  localparam logic [7:0] SDP_B1 = 8'hAC;
  localparam int DLLP_BYTES = 8;
  typedef struct packed {
    logic crc_err;
    logic [47:0] data;
  } dllp_entry_t;
  // d[31:24] is DLLP byte 2; bits go in LSB-first per byte, result is the on-wire {byte6, byte7}
  function automatic logic [15:0] dllp_crc16(input logic [31:0] d);
    logic [15:0] c;
    logic [15:0] r;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ d[8*(3-i/8) + i%8];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    c = ~c;
    for (int i = 0; i < 8; i++) begin
      r[8+i] = c[15-i];
      r[i] = c[7-i];
    end
    return r;
  endfunction
endpackage

// File: rtl/dllp_multiwrite_fifo.sv
// dllp_multiwrite_fifo: FWFT FIFO accepting up to 8 in-order pushes and one pop per cycle.
module dllp_multiwrite_fifo
  import gen3_dllp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [3:0] push_n,
  input  dllp_entry_t push_data [8],
  input  logic pop,
  output dllp_entry_t head,
  output logic head_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic [3:0] drop_n
);
  localparam int AW = $clog2(DEPTH);
  dllp_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] space, pn, acc;
  logic do_pop;
  assign do_pop = pop && head_valid;
  assign head_valid = level != '0;
  assign head = head_valid ? mem[rd_ptr] : '0;
  // a same-cycle pop frees a slot for this cycle's pushes
  assign space = (AW+1)'(DEPTH) - level + (AW+1)'(do_pop);
  assign pn = (AW+1)'(push_n);
  assign acc = pn > space ? space : pn;
  assign drop_n = 4'(pn - acc);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + acc - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++)
      if ((AW+1)'(i) < acc) mem[wr_ptr + AW'(i)] <= push_data[i];
endmodule

// File: rtl/gen3_dllp_extractor.sv
// gen3_dllp_extractor: assembles SDP-framed 8-byte DLLPs from 64-byte Gen3 beats,
// checks token and CRC, and queues them for the Data Link Layer.
module gen3_dllp_extractor
  import gen3_dllp_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [511:0] data_in,
  input  logic [63:0] valid_d,
  input  logic [63:0] dlpstart,
  input  logic [63:0] dlpend,
  output logic dllp_valid,
  input  logic dllp_ready,
  output logic [47:0] dllp_data,
  output logic dllp_crc_err,
  output logic overflow,
  output logic [CNT_W-1:0] malformed_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  logic [511:0] d_r;
  logic [63:0] v_r, s_r, e_r;
  logic col, col_n;
  logic [3:0] cnt, cnt_n, cmp_n, drop_n;
  logic [7:0] bq [DLLP_BYTES];
  logic [7:0] bq_n [DLLP_BYTES];
  logic [7:0] mal_n;
  logic [47:0] cmp [8];
  dllp_entry_t ent [8];
  dllp_entry_t head;
  logic [CNT_W:0] mal_sum, drop_sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d_r <= '0;
      v_r <= '0;
      s_r <= '0;
      e_r <= '0;
      col <= 1'b0;
      cnt <= '0;
      bq <= '{default: '0};
      malformed_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      d_r <= data_in;
      v_r <= valid_d;
      s_r <= dlpstart;
      e_r <= dlpend;
      col <= col_n;
      cnt <= cnt_n;
      bq <= bq_n;
      malformed_cnt <= mal_sum[CNT_W] ? '1 : mal_sum[CNT_W-1:0];
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      overflow <= overflow | (drop_n != '0);
    end
  // byte-serial scan of the registered beat; a carried DLLP plus seven fresh ones bound completions at 8
  always_comb begin
    col_n = col;
    cnt_n = cnt;
    bq_n = bq;
    mal_n = '0;
    cmp_n = '0;
    for (int i = 0; i < 8; i++) cmp[i] = '0;
    for (int k = 0; k < 64; k++)
      if (v_r[k]) begin
        if (s_r[k]) begin
          mal_n = mal_n + 8'(col_n);
          col_n = 1'b1;
          cnt_n = '0;
        end
        if (col_n) begin
          if (cnt_n == 4'd8) begin
            mal_n = mal_n + 8'd1;
            col_n = 1'b0;
            cnt_n = '0;
          end else begin
            bq_n[cnt_n[2:0]] = d_r[8*k +: 8];
            cnt_n = cnt_n + 4'd1;
            if (e_r[k]) begin
              if (cnt_n == 4'd8 && bq_n[0] == SDP_B0 && bq_n[1] == SDP_B1) begin
                if (cmp_n < 4'd8) cmp[cmp_n[2:0]] = {bq_n[2], bq_n[3], bq_n[4], bq_n[5], bq_n[6], bq_n[7]};
                cmp_n = cmp_n + 4'd1;
              end else mal_n = mal_n + 8'd1;
              col_n = 1'b0;
              cnt_n = '0;
            end
          end
        end
      end
  end
  for (genvar g = 0; g < 8; g++) begin : g_crc
    assign ent[g] = '{crc_err: dllp_crc16(cmp[g][47:16]) != cmp[g][15:0], data: cmp[g]};
  end
  assign mal_sum = {1'b0, malformed_cnt} + (CNT_W+1)'(mal_n);
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_n);
  dllp_multiwrite_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_n(cmp_n),
    .push_data(ent),
    .pop(dllp_ready),
    .head(head),
    .head_valid(dllp_valid),
    .level(fifo_level),
    .drop_n(drop_n)
  );
  assign dllp_data = head.data;
  assign dllp_crc_err = head.crc_err;
endmodule

// File: tb/tb_gen3_dllp_extractor.sv
// tb_gen3_dllp_extractor: directed scenarios for the DLLP extractor with an independent CRC model.
module tb_gen3_dllp_extractor;
  logic clk = 1'b0, rst = 1'b1;
  logic [511:0] din;
  logic [63:0] vd, ds, de;
  logic rdy;
  logic dllp_valid, dllp_crc_err, overflow;
  logic [47:0] dllp_data;
  logic [15:0] malformed_cnt, drop_cnt;
  logic [4:0] fifo_level;
  int tests = 0, fails = 0;

  gen3_dllp_extractor #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .data_in(din), .valid_d(vd), .dlpstart(ds), .dlpend(de),
    .dllp_valid(dllp_valid), .dllp_ready(rdy), .dllp_data(dllp_data), .dllp_crc_err(dllp_crc_err),
    .overflow(overflow), .malformed_cnt(malformed_cnt), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // CRC as polynomial long division: (M*x^16 + FFFF*x^32) mod 1100Bh, then complement and bit-reverse each byte
  function automatic logic [15:0] ref_crc(input logic [31:0] pl);
    logic [47:0] v;
    logic [31:0] m;
    logic [15:0] c;
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 8; b++) m[31-8*j-b] = pl[24-8*j+b];
    v = {m, 16'h0} ^ {16'hFFFF, 32'h0};
    for (int i = 47; i >= 16; i--) if (v[i]) v = v ^ (48'h1100B << (i - 16));
    c = ~v[15:0];
    return {c[8], c[9], c[10], c[11], c[12], c[13], c[14], c[15], c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7]};
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] tok, input logic [31:0] pl);
    return {tok, pl, ref_crc(pl)};
  endfunction

  task automatic clr();
    din = '0; vd = '0; ds = '0; de = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setb(input int p, input logic [7:0] b, input logic s, input logic e);
    din[8*p +: 8] = b; vd[p] = 1'b1; ds[p] = s; de[p] = e;
  endtask

  task automatic put(input int p, input logic [63:0] d);
    for (int i = 0; i < 8; i++) setb(p + i, d[63-8*i -: 8], i == 0, i == 7);
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; clr();
    tick(); tick();
    tests++; if (dllp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", dllp_valid); end
    tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    tests++; if ({dllp_data, dllp_crc_err} !== 49'd0) begin fails++; $display("FAIL reset_data: got %h want 0", dllp_data); end
    tests++; if ({overflow, malformed_cnt, drop_cnt} !== 33'd0) begin fails++; $display("FAIL reset_cnts: got ovf=%b mal=%0d drop=%0d want 0", overflow, malformed_cnt, drop_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    rdy = 1'b1;
    put(0, mk(16'hF0AC, 32'h0000_0005));
    tick(); clr();
    tests++; if (dllp_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b want 0", dllp_valid); end
    tick();
    tests++; if (dllp_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", dllp_valid); end
    tests++; if (dllp_data !== {32'h5, ref_crc(32'h5)}) begin fails++; $display("FAIL single_data: got %h want %h", dllp_data, {32'h5, ref_crc(32'h5)}); end
    tests++; if (dllp_crc_err !== 1'b0) begin fails++; $display("FAIL single_crc: got %b want 0", dllp_crc_err); end
    tick();
    tests++; if (dllp_valid !== 1'b0) begin fails++; $display("FAIL single_width: got %b want 0", dllp_valid); end
  endtask

  task automatic test_span();
    logic [63:0] d;
    d = mk(16'hF0AC, 32'h1234_5678);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) setb(60 + i, d[63-8*i -: 8], i == 0, 1'b0);
    tick(); clr();
    setb(0, d[31:24], 1'b0, 1'b0);
    setb(1, d[23:16], 1'b0, 1'b0);
    din[23:16] = 8'h5A; de[2] = 1'b1; ds[2] = 1'b1;
    setb(3, d[15:8], 1'b0, 1'b0);
    setb(4, d[7:0], 1'b0, 1'b1);
    tick(); clr();
    tests++; if (dllp_valid !== 1'b0) begin fails++; $display("FAIL span_early: got %b want 0", dllp_valid); end
    tick();
    tests++; if (dllp_valid !== 1'b1) begin fails++; $display("FAIL span_valid: got %b want 1", dllp_valid); end
    tests++; if ({dllp_crc_err, dllp_data} !== {1'b0, d[47:0]}) begin fails++; $display("FAIL span_data: got %b/%h want 0/%h", dllp_crc_err, dllp_data, d[47:0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    rdy = 1'b0;
    for (int k = 0; k < 8; k++) put(8 * k, mk(16'hF0AC, 32'hA000_0000 + k));
    tick(); clr(); tick();
    tests++; if (fifo_level !== 5'd8) begin fails++; $display("FAIL b2b_level: got %0d want 8", fifo_level); end
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (dllp_valid !== 1'b1 || dllp_data !== {32'hA000_0000 + k, ref_crc(32'hA000_0000 + k)})
        begin fails++; $display("FAIL b2b_order%0d: got %b/%h want 1/%h", k, dllp_valid, dllp_data, {32'hA000_0000 + k, ref_crc(32'hA000_0000 + k)}); end
      tick();
    end
    tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL b2b_drain: got %0d want 0", fifo_level); end
    rdy = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] pl;
    rdy = 1'b0;
    for (int k = 0; k < 8; k++) put(8 * k, mk(16'hF0AC, 32'hB000_0000 + k));
    tick(); clr();
    for (int k = 0; k < 4; k++) put(8 * k, mk(16'hF0AC, 32'hB000_0008 + k));
    tick(); clr();
    for (int k = 0; k < 8; k++) put(8 * k, mk(16'hF0AC, 32'hC000_0000 + k));
    tick(); clr(); tick();
    tests++; if (fifo_level !== 5'd16) begin fails++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
    tests++; if (drop_cnt !== 16'd4) begin fails++; $display("FAIL ovf_drop: got %0d want 4", drop_cnt); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      pl = k < 12 ? 32'hB000_0000 + k : 32'hC000_0000 + (k - 12);
      tests++;
      if (dllp_valid !== 1'b1 || dllp_data !== {pl, ref_crc(pl)})
        begin fails++; $display("FAIL ovf_order%0d: got %b/%h want 1/%h", k, dllp_valid, dllp_data, {pl, ref_crc(pl)}); end
      tick();
    end
    tests++; if (fifo_level !== 5'd0 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got lvl=%0d ovf=%b want 0/1", fifo_level, overflow); end
    rdy = 1'b0;
  endtask

  task automatic test_malformed();
    logic [63:0] d;
    rdy = 1'b0;
    d = mk(16'hF0AD, 32'h1111_2222);
    setb(0, 8'hF0, 1'b1, 1'b0); setb(1, 8'hAC, 1'b0, 1'b0); setb(2, 8'h00, 1'b0, 1'b0);
    put(3, d);
    d = mk(16'hF0AC, 32'h3333_4444);
    for (int i = 0; i < 6; i++) setb(16 + i, d[63-8*i -: 8], i == 0, i == 5);
    tick(); clr(); tick();
    tests++; if (malformed_cnt !== 16'd3) begin fails++; $display("FAIL mal_count: got %0d want 3", malformed_cnt); end
    tests++; if (fifo_level !== 5'd0 || dllp_valid !== 1'b0) begin fails++; $display("FAIL mal_nowrite: got lvl=%0d v=%b want 0/0", fifo_level, dllp_valid); end
    d = mk(16'hF0AC, 32'hDEAD_BEEF) ^ 64'h1;
    put(0, d);
    d = mk(16'hF0AC, 32'h5555_6666);
    for (int i = 0; i < 8; i++) setb(8 + i, d[63-8*i -: 8], i == 0, 1'b0);
    setb(16, 8'h77, 1'b0, 1'b1);
    tick(); clr(); tick();
    tests++; if (dllp_valid !== 1'b1 || dllp_crc_err !== 1'b1) begin fails++; $display("FAIL crc_bad: got v=%b err=%b want 1/1", dllp_valid, dllp_crc_err); end
    tests++; if (dllp_data !== {32'hDEAD_BEEF, ref_crc(32'hDEAD_BEEF) ^ 16'h1}) begin fails++; $display("FAIL crc_data: got %h want %h", dllp_data, {32'hDEAD_BEEF, ref_crc(32'hDEAD_BEEF) ^ 16'h1}); end
    tests++; if (malformed_cnt !== 16'd4 || fifo_level !== 5'd1) begin fails++; $display("FAIL ninth_byte: got mal=%0d lvl=%0d want 4/1", malformed_cnt, fifo_level); end
    tick();
    tests++; if (dllp_valid !== 1'b1 || dllp_crc_err !== 1'b1 || dllp_data[47:16] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hold_stable: got v=%b err=%b d=%h want 1/1/deadbeef....", dllp_valid, dllp_crc_err, dllp_data); end
    rdy = 1'b1;
    tick();
    tests++; if (dllp_valid !== 1'b0) begin fails++; $display("FAIL crc_pop: got %b want 0", dllp_valid); end
    rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) put(8 * k, mk(16'hF0AC, 32'hE000_0000 + k));
    tick(); clr();
    d = mk(16'hF0AC, 32'h0BAD_0BAD);
    for (int i = 0; i < 4; i++) setb(i, d[63-8*i -: 8], i == 0, 1'b0);
    tick(); clr(); tick();
    tests++; if (fifo_level !== 5'd5) begin fails++; $display("FAIL rmid_pre: got %0d want 5", fifo_level); end
    rst = 1'b1; #1;
    tests++; if ({dllp_valid, fifo_level, dllp_data, dllp_crc_err} !== 55'd0) begin fails++; $display("FAIL rmid_outs: got v=%b lvl=%0d d=%h want 0", dllp_valid, fifo_level, dllp_data); end
    tests++; if ({overflow, malformed_cnt, drop_cnt} !== 33'd0) begin fails++; $display("FAIL rmid_cnts: got ovf=%b mal=%0d drop=%0d want 0", overflow, malformed_cnt, drop_cnt); end
    tick();
    rst = 1'b0;
    tick();
    rdy = 1'b1;
    put(0, mk(16'hF0AC, 32'h0000_00AB));
    tick(); clr(); tick();
    tests++; if (dllp_valid !== 1'b1 || dllp_data !== {32'hAB, ref_crc(32'hAB)}) begin fails++; $display("FAIL rmid_clean: got %b/%h want 1/%h", dllp_valid, dllp_data, {32'hAB, ref_crc(32'hAB)}); end
    tests++; if (malformed_cnt !== 16'd0) begin fails++; $display("FAIL rmid_partial: got %0d want 0", malformed_cnt); end
    tick();
  endtask

  initial begin
    clr();
    rdy = 1'b0;
    test_reset();
    test_single();
    test_span();
    test_back_to_back();
    test_overflow();
    test_malformed();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
